// File: rtl/pdp_mem_arbiter.sv
// Arbiter for the single memory_pdp port between the IF (read-only) and EX (read/write) requesters.
// Ties go round-robin by default; define PDP_ARB_EX_PRIORITY_EN for fixed EX priority.
module pdp_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_rd_req,
    input  logic [ADDR_WIDTH-1:0] if_rd_addr,
    output logic                  if_gnt,
    output logic                  if_rd_valid,
    output logic [DATA_WIDTH-1:0] if_rd_data,

    input  logic                  ex_rd_req,
    input  logic                  ex_wr_req,
    input  logic [ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic [ADDR_WIDTH-1:0] ex_wr_addr,
    input  logic [DATA_WIDTH-1:0] ex_wr_data,
    output logic                  ex_gnt,
    output logic                  ex_rd_valid,
    output logic [DATA_WIDTH-1:0] ex_rd_data,

    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,

    output logic                  arb_busy,
    output logic [1:0]            state_dbg
);

    // Handshake: a requester holds its req until it sees a one-cycle gnt, then drops
    // it in the following cycle; requests are only sampled in IDLE, so a held req is
    // never granted twice. rd_valid is a one-cycle pulse with rd_data valid alongside.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state;
    logic   owner_ex;
    logic   op_wr;
    logic   if_pend;
    logic   ex_pend;
    logic   pick_ex;
    logic   pick_wr;

    assign if_pend = if_rd_req;
    assign ex_pend = ex_rd_req | ex_wr_req;

`ifdef PDP_ARB_EX_PRIORITY_EN
    assign pick_ex = ex_pend;
`else
    logic last_gnt_ex;

    // The requester that did not win last time takes a tie.
    assign pick_ex = ex_pend & (~if_pend | ~last_gnt_ex);
`endif

    // Within EX a pending write goes ahead of a pending read.
    assign pick_wr = pick_ex & ex_wr_req;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner_ex    <= 1'b0;
            op_wr       <= 1'b0;
            if_gnt      <= 1'b0;
            ex_gnt      <= 1'b0;
            if_rd_valid <= 1'b0;
            ex_rd_valid <= 1'b0;
            if_rd_data  <= '0;
            ex_rd_data  <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            arb_busy    <= 1'b0;
`ifndef PDP_ARB_EX_PRIORITY_EN
            last_gnt_ex <= 1'b1;
`endif
        end else begin
            if_gnt      <= 1'b0;
            ex_gnt      <= 1'b0;
            if_rd_valid <= 1'b0;
            ex_rd_valid <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (if_pend || ex_pend) begin
                        owner_ex <= pick_ex;
                        op_wr    <= pick_wr;
                        state    <= ST_ISSUE;
                        arb_busy <= 1'b1;
`ifndef PDP_ARB_EX_PRIORITY_EN
                        last_gnt_ex <= pick_ex;
`endif
                        // Grant and strobe are launched together so they coincide in ISSUE.
                        if (pick_ex) begin
                            ex_gnt <= 1'b1;
                        end else begin
                            if_gnt <= 1'b1;
                        end
                        if (pick_wr) begin
                            mem_wr_req  <= 1'b1;
                            mem_wr_addr <= ex_wr_addr;
                            mem_wr_data <= ex_wr_data;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= pick_ex ? ex_rd_addr : if_rd_addr;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (op_wr) begin
                        state    <= ST_IDLE;
                        arb_busy <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Memory data is valid this cycle; only the owner's register changes.
                    if (owner_ex) begin
                        ex_rd_data  <= mem_rd_data;
                        ex_rd_valid <= 1'b1;
                    end else begin
                        if_rd_data  <= mem_rd_data;
                        if_rd_valid <= 1'b1;
                    end
                    state <= ST_RESP;
                end

                ST_RESP: begin
                    state    <= ST_IDLE;
                    arb_busy <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Self-checking bench for pdp_mem_arbiter: directed cases plus concurrent random IF/EX traffic
// checked by an expected-queue scoreboard and a transaction-level arbitration model.
module tb_pdp_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;

`ifdef PDP_ARB_EX_PRIORITY_EN
    localparam bit FIRST_TIE_EX = 1'b1;
`else
    localparam bit FIRST_TIE_EX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_rd_req = 1'b0;
    logic [AW-1:0] if_rd_addr = '0;
    logic          if_gnt, if_rd_valid;
    logic [DW-1:0] if_rd_data;
    logic          ex_rd_req = 1'b0, ex_wr_req = 1'b0;
    logic [AW-1:0] ex_rd_addr = '0, ex_wr_addr = '0;
    logic [DW-1:0] ex_wr_data = '0;
    logic          ex_gnt, ex_rd_valid;
    logic [DW-1:0] ex_rd_data;
    logic          mem_rd_req, mem_wr_req;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] mem_wr_data;
    logic          arb_busy;
    logic [1:0]    state_dbg;

    pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .if_rd_req(if_rd_req), .if_rd_addr(if_rd_addr), .if_gnt(if_gnt),
        .if_rd_valid(if_rd_valid), .if_rd_data(if_rd_data),
        .ex_rd_req(ex_rd_req), .ex_wr_req(ex_wr_req), .ex_rd_addr(ex_rd_addr),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_gnt(ex_gnt),
        .ex_rd_valid(ex_rd_valid), .ex_rd_data(ex_rd_data),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .arb_busy(arb_busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] ref_mem [4096];

    always @(posedge clk) begin
        if (mem_wr_req) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr];
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0]    if_exp_q[$];
    logic [DW-1:0]    ex_exp_q[$];
    logic [AW-1:0]    if_addr_q[$];
    logic [AW-1:0]    ex_addr_q[$];
    logic [AW+DW-1:0] wr_exp_q[$];
    logic             gnt_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic wait_gnt(input bit ex);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            seen = ex ? ex_gnt : if_gnt;
        end
        check(ex ? "ex_gnt_wait" : "if_gnt_wait", {31'b0, seen}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic if_read(input logic [AW-1:0] a);
        if_addr_q.push_back(a);
        if_exp_q.push_back(ref_mem[a]);
        if_rd_addr = a;
        if_rd_req  = 1'b1;
        wait_gnt(1'b0);
        step(1);
        if_rd_req = 1'b0;
    endtask

    task automatic ex_read(input logic [AW-1:0] a);
        ex_addr_q.push_back(a);
        ex_exp_q.push_back(ref_mem[a]);
        ex_rd_addr = a;
        ex_rd_req  = 1'b1;
        wait_gnt(1'b1);
        step(1);
        ex_rd_req = 1'b0;
    endtask

    task automatic ex_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a] = d;
        wr_exp_q.push_back({a, d});
        ex_wr_addr = a;
        ex_wr_data = d;
        ex_wr_req  = 1'b1;
        wait_gnt(1'b1);
        step(1);
        ex_wr_req = 1'b0;
    endtask

    // Read and write raised together: the write is served first, so the read sees it.
    task automatic ex_both(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic [DW-1:0] d);
        ref_mem[wa] = d;
        wr_exp_q.push_back({wa, d});
        ex_addr_q.push_back(ra);
        ex_exp_q.push_back(ref_mem[ra]);
        ex_rd_addr = ra;
        ex_wr_addr = wa;
        ex_wr_data = d;
        ex_rd_req  = 1'b1;
        ex_wr_req  = 1'b1;
        wait_gnt(1'b1);
        step(1);
        ex_wr_req = 1'b0;
        wait_gnt(1'b1);
        step(1);
        ex_rd_req = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        if_exp_q.delete();
        ex_exp_q.delete();
        if_addr_q.delete();
        ex_addr_q.delete();
        wr_exp_q.delete();
        step(1);
        reset = 1'b0;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ex_gnt", ex_gnt, 0);
        check("rst_if_rd_valid", if_rd_valid, 0);
        check("rst_ex_rd_valid", ex_rd_valid, 0);
        check("rst_if_rd_data", if_rd_data, 0);
        check("rst_ex_rd_data", ex_rd_data, 0);
        check("rst_mem_rd_req", mem_rd_req, 0);
        check("rst_mem_wr_req", mem_wr_req, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_mem_wr_addr", mem_wr_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_arb_busy", arb_busy, 0);
    endtask

    task automatic if_stream(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3));
            if_read(AW'($urandom_range(0, 2047)));
        end
    endtask

    task automatic ex_stream(input int n);
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] d;
        int            op;
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            wa = {1'b1, 11'($urandom_range(0, 2047))};
            ra = {1'b1, 11'($urandom_range(0, 2047))};
            d  = DW'($urandom_range(0, 4095));
            if (op == 0) ex_write(wa, d);
            else if (op == 1) ex_read(ra);
            else ex_both(($urandom_range(0, 1) == 1) ? wa : ra, wa, d);
        end
    endtask

    task automatic check_gnt_log(input string name, input int n, input logic [3:0] exp_bits);
        check({name, "_count"}, gnt_log.size(), n);
        if (gnt_log.size() == n) begin
            for (int i = 0; i < n; i++) check($sformatf("%s_%0d", name, i), gnt_log[i], exp_bits[i]);
        end
    endtask

    // ---------------- monitor: arbitration model + scoreboard ----------------
    // The model tracks, per cycle, whether the arbiter was free to take a request in the
    // previous cycle and, if so, who should have won; an access then occupies the port
    // for one cycle (write) or three (read), with rd_valid two cycles after the grant.
    int cyc = 0;
    int if_due = -1;
    int ex_due = -1;
    int busy_left = 0;
    bit prev_rst = 1'b1, prev_idle = 1'b1, prev_if = 1'b0, prev_ex = 1'b0, prev_ex_wr = 1'b0;
    bit last_ex = 1'b1;
    logic [DW-1:0] prev_if_data = '0, prev_ex_data = '0;

    always @(negedge clk) begin : monitor
        bit g_if, g_ex, g_rd, g_wr, idle_now, win_ex;
        cyc++;
        g_if = 1'b0; g_ex = 1'b0; g_rd = 1'b0; g_wr = 1'b0; win_ex = 1'b0;
        if (prev_rst) begin
            busy_left = 0; last_ex = 1'b1; if_due = -1; ex_due = -1; idle_now = 1'b1;
            prev_if_data = '0; prev_ex_data = '0;
        end else if (prev_idle && (prev_if || prev_ex)) begin
            win_ex = FIRST_TIE_EX ? prev_ex : (prev_ex && (!prev_if || !last_ex));
            last_ex = win_ex;
            g_ex = win_ex;
            g_if = !win_ex;
            g_wr = win_ex && prev_ex_wr;
            g_rd = !g_wr;
            busy_left = g_wr ? 0 : 2;
            idle_now = 1'b0;
            if (g_rd && win_ex) ex_due = cyc + 2;
            if (g_rd && !win_ex) if_due = cyc + 2;
        end else if (busy_left > 0) begin
            busy_left--;
            idle_now = 1'b0;
        end else begin
            idle_now = 1'b1;
        end

        check("if_gnt", if_gnt, g_if);
        check("ex_gnt", ex_gnt, g_ex);
        check("mem_rd_req", mem_rd_req, g_rd);
        check("mem_wr_req", mem_wr_req, g_wr);
        check("arb_busy", arb_busy, !idle_now);
        check("if_rd_valid", if_rd_valid, if_due == cyc);
        check("ex_rd_valid", ex_rd_valid, ex_due == cyc);

        if (if_gnt) gnt_log.push_back(1'b0);
        if (ex_gnt) gnt_log.push_back(1'b1);

        if (mem_rd_req && g_rd) begin
            if (g_ex && ex_addr_q.size() > 0) check("ex_mem_rd_addr", mem_rd_addr, ex_addr_q.pop_front());
            else if (g_if && if_addr_q.size() > 0) check("if_mem_rd_addr", mem_rd_addr, if_addr_q.pop_front());
            else check("mem_rd_req_unexpected", mem_rd_req, 0);
        end
        if (mem_wr_req && g_wr) begin
            if (wr_exp_q.size() > 0) check("mem_wr_addr_data", {mem_wr_addr, mem_wr_data}, wr_exp_q.pop_front());
            else check("mem_wr_req_unexpected", mem_wr_req, 0);
        end

        if (if_rd_valid) begin
            if (if_exp_q.size() > 0) check("if_rd_data", if_rd_data, if_exp_q.pop_front());
            else check("if_rd_valid_unexpected", if_rd_valid, 0);
        end else begin
            check("if_rd_data_hold", if_rd_data, prev_if_data);
        end
        if (ex_rd_valid) begin
            if (ex_exp_q.size() > 0) check("ex_rd_data", ex_rd_data, ex_exp_q.pop_front());
            else check("ex_rd_valid_unexpected", ex_rd_valid, 0);
        end else begin
            check("ex_rd_data_hold", ex_rd_data, prev_ex_data);
        end

        prev_if_data = if_rd_data;
        prev_ex_data = ex_rd_data;
        prev_rst     = reset;
        prev_idle    = idle_now;
        prev_if      = if_rd_req;
        prev_ex      = ex_rd_req | ex_wr_req;
        prev_ex_wr   = ex_wr_req;
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'(i * 5 + 3);
            ref_mem[i] = DW'(i * 5 + 3);
        end
        step(3);
        reset = 1'b0;

        // Single IF read.
        mem[12'o200]     = 12'o7300;
        ref_mem[12'o200] = 12'o7300;
        if_read(12'o200);
        step(3);
        check("t1_if_rd_data", if_rd_data, 12'o7300);
        check("t1_arb_busy_idle", arb_busy, 0);

        // Single EX write.
        ex_write(12'o050, 12'o1234);
        step(2);
        check("t2_mem_written", mem[12'o050], 12'o1234);
        check("t2_ex_rd_data_untouched", ex_rd_data, 0);

        // Back-to-back ties between IF and EX reads.
        gnt_log.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                if_read(AW'(12'o300 + r));
                ex_read(AW'(12'o4000 + r));
            join
        end
        step(6);
        check_gnt_log("t3_tie", 4, {!FIRST_TIE_EX, FIRST_TIE_EX, !FIRST_TIE_EX, FIRST_TIE_EX});

        // EX read and write together, same address.
        gnt_log.delete();
        ex_both(12'o5000, 12'o5000, 12'o4321);
        step(4);
        check_gnt_log("t4_both", 2, 4'b0011);
        check("t4_ex_rd_data", ex_rd_data, 12'o4321);

        // Reset while an IF read sits in WAIT, then a fresh tie.
        if_read(12'o310);
        reset_pulse();
        step(5);
        check("t5_no_if_data", if_rd_data, 0);
        gnt_log.delete();
        fork
            if_read(12'o311);
            ex_read(12'o4100);
        join
        step(6);
        check_gnt_log("t5_tie", 2, {2'b00, !FIRST_TIE_EX, FIRST_TIE_EX});

        // Concurrent random traffic.
        fork
            if_stream(40);
            ex_stream(40);
        join
        step(8);
        check("drain_if_exp_q", if_exp_q.size(), 0);
        check("drain_ex_exp_q", ex_exp_q.size(), 0);
        check("drain_wr_exp_q", wr_exp_q.size(), 0);
        check("drain_addr_q", if_addr_q.size() + ex_addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
